// File: rtl/axi_dma_rd_engine_pkg.sv
// Shared AXI read-channel field widths, protocol codes and engine state encoding.
package axi_dma_rd_engine_pkg;

    localparam int unsigned AXI_ID_W    = 4;
    localparam int unsigned AXI_LEN_W   = 8;
    localparam int unsigned AXI_SIZE_W  = 3;
    localparam int unsigned AXI_BURST_W = 2;
    localparam int unsigned AXI_CACHE_W = 4;
    localparam int unsigned AXI_PROT_W  = 3;
    localparam int unsigned AXI_QOS_W   = 4;
    localparam int unsigned AXI_RESP_W  = 2;

    localparam logic [AXI_BURST_W-1:0] BURST_INCR  = 2'b01;
    localparam logic [AXI_RESP_W-1:0]  RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_W-1:0]  RESP_SLVERR = 2'b10;
    localparam logic [AXI_RESP_W-1:0]  RESP_DECERR = 2'b11;

    // Normal, non-bufferable; unprivileged, non-secure, data access.
    localparam logic [AXI_CACHE_W-1:0] AR_CACHE = 4'h2;
    localparam logic [AXI_PROT_W-1:0]  AR_PROT  = 3'b010;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StDone
    } state_e;

endpackage

// File: rtl/axi_dma_rd_engine_if.sv
// AXI read-address/read-data channels plus the outgoing beat stream of the DMA read engine.
interface axi_dma_rd_engine_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 256
);
    import axi_dma_rd_engine_pkg::*;

    logic [AXI_ID_W-1:0]    arid;
    logic [ADDR_W-1:0]      araddr;
    logic [AXI_LEN_W-1:0]   arlen;
    logic [AXI_SIZE_W-1:0]  arsize;
    logic [AXI_BURST_W-1:0] arburst;
    logic                   arlock;
    logic [AXI_CACHE_W-1:0] arcache;
    logic [AXI_PROT_W-1:0]  arprot;
    logic [AXI_QOS_W-1:0]   arqos;
    logic                   arvalid;
    logic                   arready;

    logic [AXI_ID_W-1:0]    rid;
    logic [DATA_W-1:0]      rdata;
    logic [AXI_RESP_W-1:0]  rresp;
    logic                   rlast;
    logic                   rvalid;
    logic                   rready;

    logic                   m_tvalid;
    logic [DATA_W-1:0]      m_tdata;
    logic                   m_tlast;
    logic                   m_tready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output m_tvalid, m_tdata, m_tlast,
        input  m_tready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  m_tvalid, m_tdata, m_tlast,
        output m_tready
    );

endinterface

// File: rtl/axi_dma_burst_calc.sv
// Beats for the next burst: min(remaining, MAX_BURST, beats left before the next 4 KB page).
module axi_dma_burst_calc #(
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned MAX_BURST = 16,
    localparam int unsigned SIZE     = $clog2(DATA_W / 8),
    localparam int unsigned BEAT_W   = $clog2(MAX_BURST) + 1
) (
    input  logic [11-SIZE:0]  blk_idx,    // beat index within the current 4 KB page
    input  logic [LEN_W-1:0]  remaining,
    output logic [BEAT_W-1:0] beats
);

    localparam int unsigned CW = (LEN_W > 13) ? LEN_W : 13;

    logic [12:0]   page_beats;
    logic [CW-1:0] pick;

    assign page_beats = (13'h1000 >> SIZE) - 13'(blk_idx);

    always_comb begin
        pick = (CW'(remaining) < CW'(MAX_BURST)) ? CW'(remaining) : CW'(MAX_BURST);
        if (CW'(page_beats) < pick) begin
            pick = CW'(page_beats);
        end
        beats = BEAT_W'(pick);
    end

endmodule

// File: rtl/axi_dma_rd_engine.sv
// Single-outstanding AXI burst reader: splits a beat-count transfer into 4 KB-safe bursts and
// streams the returned data straight through to m_t*.
module axi_dma_rd_engine
    import axi_dma_rd_engine_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              error,
    axi_dma_rd_engine_if.master bus
);

    localparam int unsigned BYTES  = DATA_W / 8;
    localparam int unsigned SIZE   = $clog2(BYTES);
    localparam int unsigned BEAT_W = $clog2(MAX_BURST) + 1;

    state_e               state_q;
    logic [ADDR_W-1:0]    araddr_q;
    logic [AXI_LEN_W-1:0] arlen_q;
    logic                 arvalid_q;
    logic [BEAT_W-1:0]    burst_cnt_q;
    logic [LEN_W-1:0]     xfer_cnt_q;

    logic [ADDR_W-1:0]    base_aligned;
    logic [ADDR_W-1:0]    next_addr;
    logic [11-SIZE:0]     calc_blk;
    logic [LEN_W-1:0]     calc_rem;
    logic [BEAT_W-1:0]    calc_beats;
    logic                 beat;
    logic                 burst_end;
    logic                 beat_err;
    logic                 unused_rid;

    assign base_aligned = base_addr & ~ADDR_W'(BYTES - 1);
    assign next_addr    = araddr_q + ((ADDR_W'(arlen_q) + ADDR_W'(1)) << SIZE);

    // In IDLE the first burst is sized from the request; in DATA the follow-on burst is sized
    // on the closing beat, so the remaining count excludes that beat.
    assign calc_blk = (state_q == StIdle) ? base_aligned[11:SIZE] : next_addr[11:SIZE];
    assign calc_rem = (state_q == StIdle) ? len : xfer_cnt_q - LEN_W'(1);

    axi_dma_burst_calc #(
        .DATA_W    (DATA_W),
        .LEN_W     (LEN_W),
        .MAX_BURST (MAX_BURST)
    ) u_burst_calc (
        .blk_idx   (calc_blk),
        .remaining (calc_rem),
        .beats     (calc_beats)
    );

    assign beat      = (state_q == StData) && bus.rvalid && bus.m_tready;
    assign burst_end = (burst_cnt_q == BEAT_W'(1));
    assign beat_err  = (bus.rresp != RESP_OKAY) || (bus.rlast != burst_end);

    assign bus.arid     = '0;
    assign bus.araddr   = araddr_q;
    assign bus.arlen    = arlen_q;
    assign bus.arsize   = AXI_SIZE_W'(SIZE);
    assign bus.arburst  = BURST_INCR;
    assign bus.arlock   = 1'b0;
    assign bus.arcache  = AR_CACHE;
    assign bus.arprot   = AR_PROT;
    assign bus.arqos    = '0;
    assign bus.arvalid  = arvalid_q;
    assign bus.rready   = (state_q == StData) && bus.m_tready;
    assign bus.m_tvalid = (state_q == StData) && bus.rvalid;
    assign bus.m_tdata  = bus.rdata;
    assign bus.m_tlast  = (state_q == StData) && (xfer_cnt_q == LEN_W'(1));
    assign unused_rid   = ^bus.rid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arvalid_q   <= 1'b0;
            burst_cnt_q <= '0;
            xfer_cnt_q  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        error <= 1'b0;
                        if (len == '0) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            state_q     <= StAddr;
                            busy        <= 1'b1;
                            arvalid_q   <= 1'b1;
                            araddr_q    <= base_aligned;
                            arlen_q     <= AXI_LEN_W'(calc_beats - BEAT_W'(1));
                            burst_cnt_q <= calc_beats;
                            xfer_cnt_q  <= len;
                        end
                    end
                end
                StAddr: begin
                    if (bus.arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (beat) begin
                        burst_cnt_q <= burst_cnt_q - BEAT_W'(1);
                        xfer_cnt_q  <= xfer_cnt_q - LEN_W'(1);
                        if (beat_err) begin
                            error <= 1'b1;
                        end
                        if (xfer_cnt_q == LEN_W'(1)) begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else if (burst_end) begin
                            state_q     <= StAddr;
                            arvalid_q   <= 1'b1;
                            araddr_q    <= next_addr;
                            arlen_q     <= AXI_LEN_W'(calc_beats - BEAT_W'(1));
                            burst_cnt_q <= calc_beats;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_dma_rd_engine.sv
// Bench for axi_dma_rd_engine: a scripted AXI slave answers reads while separate monitors
// pop expected AR requests and stream beats from scoreboard queues.
module tb_axi_dma_rd_engine;
    import axi_dma_rd_engine_pkg::*;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 256;
    localparam int unsigned LEN_W     = 16;
    localparam int unsigned MAX_BURST = 16;

    typedef struct {
        logic [255:0] data;
        logic         last;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        error;

    axi_dma_rd_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axi_dma_rd_engine #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LEN_W     (LEN_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    beat_t exp_q[$];
    ar_t   exp_ar[$];
    beat_t eb;
    ar_t   ea;
    int    checks = 0;
    int    errors = 0;

    // Slave knobs and state.
    int          ar_delay = 0;
    int          err_beat = 0;
    int          last_beat = 0;
    bit          tready_toggle = 1'b0;
    bit          have_burst = 1'b0;
    bit          ar_hold = 1'b0;
    logic [39:0] ar_held;
    logic [31:0] cur_addr = '0;
    int          beats_left = 0;
    int          xfer_beat = 0;
    int          ar_cnt = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic logic [255:0] pat(input logic [31:0] a);
        logic [31:0] w;
        w = a ^ 32'h5A00_0000;
        return {8{w}};
    endfunction

    task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
        ar_t t;
        t.addr = a;
        t.len  = l;
        exp_ar.push_back(t);
    endtask

    task automatic push_beats(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            beat_t b;
            b.data = pat(base + 32'(k * 32));
            b.last = (k == n - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic do_xfer(input string name, input logic [31:0] base, input int n,
                           input logic exp_err, input int poke);
        bit got = 1'b0;
        int done_at = -1;
        push_beats(base & ~32'h1F, n);
        xfer_beat = 0;
        @(negedge clk);
        start     = 1'b1;
        base_addr = base;
        len       = 16'(n);
        @(negedge clk);
        start = 1'b0;
        chk({name, "_busy_after_start"}, busy, n != 0);
        chk({name, "_error_cleared"}, error, 1'b0);
        for (int c = 0; c < 600; c++) begin
            if (done) begin
                got     = 1'b1;
                done_at = c;
                break;
            end
            if (c == poke) begin
                start     = 1'b1;
                base_addr = 32'h0000_3000;
                len       = 16'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!got) begin
            flag({name, "_done"}, "timeout waiting for done");
        end else begin
            if (n == 0) chk({name, "_done_latency"}, done_at, 0);
            chk({name, "_busy_low_at_done"}, busy, 1'b0);
            chk({name, "_error_at_done"}, error, exp_err);
            chk({name, "_beats_outstanding"}, exp_q.size(), 0);
            chk({name, "_ars_outstanding"}, exp_ar.size(), 0);
            chk({name, "_arvalid_at_done"}, bus.arvalid, 1'b0);
            @(negedge clk);
            chk({name, "_done_single_cycle"}, done, 1'b0);
        end
    endtask

    // AXI slave: drive on negedge, then judge the handshakes that the next posedge will take.
    initial begin : slave
        bus.arready  = 1'b0;
        bus.rid      = '0;
        bus.rdata    = '0;
        bus.rresp    = RESP_OKAY;
        bus.rlast    = 1'b0;
        bus.rvalid   = 1'b0;
        bus.m_tready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_burst  = 1'b0;
                ar_hold     = 1'b0;
                ar_cnt      = 0;
                bus.arready = 1'b0;
                bus.rvalid  = 1'b0;
                bus.rlast   = 1'b0;
                bus.rresp   = RESP_OKAY;
                continue;
            end
            bus.m_tready = tready_toggle ? ~bus.m_tready : 1'b1;
            if (bus.arvalid && !have_burst) begin
                bus.arready = (ar_cnt >= ar_delay);
                if (!bus.arready) ar_cnt++;
            end else begin
                bus.arready = 1'b0;
            end
            bus.rvalid = have_burst;
            bus.rdata  = pat(cur_addr);
            bus.rlast  = have_burst && (beats_left == 1 || xfer_beat + 1 == last_beat);
            bus.rresp  = (have_burst && xfer_beat + 1 == err_beat) ? RESP_SLVERR : RESP_OKAY;
            #1;
            if (have_burst && !rst) chk("rready_mirrors_tready", bus.rready, bus.m_tready);
            if (bus.arvalid) begin
                if (ar_hold) chk("ar_stable", {bus.araddr, bus.arlen}, ar_held);
                if (bus.arready) begin
                    ar_hold = 1'b0;
                    ar_cnt  = 0;
                    if (exp_ar.size() == 0) begin
                        flag("unexpected_ar", $sformatf("addr %0h len %0d", bus.araddr, bus.arlen));
                    end else begin
                        ea = exp_ar.pop_front();
                        chk("ar_addr", bus.araddr, ea.addr);
                        chk("ar_len", bus.arlen, ea.len);
                    end
                    chk("ar_const", {bus.arid, bus.arsize, bus.arburst, bus.arlock, bus.arcache,
                                     bus.arprot, bus.arqos},
                        {4'h0, 3'd5, 2'b01, 1'b0, 4'h2, 3'b010, 4'h0});
                    have_burst = 1'b1;
                    cur_addr   = bus.araddr;
                    beats_left = int'(bus.arlen) + 1;
                end else begin
                    ar_hold = 1'b1;
                    ar_held = {bus.araddr, bus.arlen};
                end
            end
            if (bus.rvalid && bus.rready) begin
                cur_addr += 32;
                beats_left--;
                xfer_beat++;
                if (beats_left == 0) have_burst = 1'b0;
            end
        end
    end

    // Stream monitor.
    always @(negedge clk) begin
        #2;
        if (!rst && bus.m_tvalid && bus.m_tready) begin
            if (exp_q.size() == 0) begin
                flag("unexpected_beat", $sformatf("data %0h", bus.m_tdata));
            end else begin
                eb = exp_q.pop_front();
                chk("beat_data", bus.m_tdata, eb.data);
                chk("beat_last", bus.m_tlast, eb.last);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        #12;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_error", error, 1'b0);
        chk("reset_arvalid", bus.arvalid, 1'b0);
        chk("reset_rready", bus.rready, 1'b0);
        chk("reset_tvalid", bus.m_tvalid, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        push_ar(32'h000, 8'd15);
        do_xfer("single16", 32'h000, 16, 1'b0, -1);

        push_ar(32'h000, 8'd15);
        push_ar(32'h200, 8'd15);
        push_ar(32'h400, 8'd7);
        do_xfer("len40", 32'h000, 40, 1'b0, 10);

        push_ar(32'hF80, 8'd3);
        push_ar(32'h1000, 8'd11);
        do_xfer("cross4k", 32'hF80, 16, 1'b0, -1);

        tready_toggle = 1'b1;
        ar_delay      = 3;
        push_ar(32'h2000, 8'd15);
        do_xfer("backpressure", 32'h2000, 16, 1'b0, -1);
        tready_toggle = 1'b0;
        ar_delay      = 0;

        err_beat = 5;
        push_ar(32'h000, 8'd15);
        do_xfer("slverr", 32'h000, 16, 1'b1, -1);
        err_beat = 0;

        last_beat = 8;
        push_ar(32'h000, 8'd15);
        do_xfer("early_rlast", 32'h000, 16, 1'b1, -1);
        last_beat = 0;

        do_xfer("len0", 32'h100, 0, 1'b0, -1);

        // Reset in the middle of a burst after an error has been latched.
        err_beat = 2;
        push_ar(32'h000, 8'd15);
        push_beats(32'h000, 16);
        xfer_beat = 0;
        @(negedge clk);
        start     = 1'b1;
        base_addr = 32'h000;
        len       = 16'd16;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_pre_error", error, 1'b1);
        chk("midrst_pre_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_error", error, 1'b0);
        chk("midrst_arvalid", bus.arvalid, 1'b0);
        chk("midrst_rready", bus.rready, 1'b0);
        chk("midrst_tvalid", bus.m_tvalid, 1'b0);
        exp_q.delete();
        exp_ar.delete();
        err_beat = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        push_ar(32'h1FE0, 8'd0);
        push_ar(32'h2000, 8'd1);
        do_xfer("page_tail", 32'h1FE0, 3, 1'b0, -1);

        push_ar(32'h100, 8'd1);
        do_xfer("unaligned", 32'h10F, 2, 1'b0, -1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
